// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit. It holds the PC, addresses a
// combinational instruction memory and fills the IF/ID register.
//
// Ports:
//   clk, reset              clock and sync active-high reset
//   stall                   freeze PC and IF/ID
//   npc_op                  0 seq, 1 branch, 2 j/jal, 3 jr/jalr
//   id_pc, id_imm16,
//   id_index26, id_rs_val   redirect operands from ID
//   im_addr / im_instr      memory byte address / returned word
//   if_id_*                 IF/ID pipeline register outputs
//
// Optional: define IFU_ADEL_EN to flag misaligned or out-of-range
// fetches. A faulting fetch latches a nop and sets if_id_exc.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned IM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  npc_op,
    input  logic [31:0] id_pc,
    input  logic [15:0] id_imm16,
    input  logic [25:0] id_index26,
    input  logic [31:0] id_rs_val,
    output logic [31:0] im_addr,
    input  logic [31:0] im_instr,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc8,
    output logic        if_id_valid,
    output logic        if_id_exc
);

    logic [31:0] pc_q;
    logic [31:0] pc4;
    logic [31:0] id_pc4;
    logic [31:0] br_off;
    logic [31:0] npc;
    logic [31:0] instr_d;

    assign im_addr = pc_q;
    assign pc4     = pc_q + 32'd4;
    assign id_pc4  = id_pc + 32'd4;
    assign br_off  = {{14{id_imm16[15]}}, id_imm16, 2'b00};

    // Redirects are resolved in ID, so the word being fetched this
    // cycle is the delay slot and is latched as usual.
    always_comb begin
        npc = pc4;
        unique case (npc_op)
            2'd0: npc = pc4;
            2'd1: npc = id_pc4 + br_off;
            2'd2: npc = {id_pc4[31:28], id_index26, 2'b00};
            2'd3: npc = id_rs_val;
        endcase
    end

`ifdef IFU_ADEL_EN
    localparam logic [31:0] PC_LIMIT = RESET_PC + 32'(4 * IM_WORDS);

    logic fault;

    assign fault = (pc_q[1:0] != 2'b00)
                 | (pc_q < RESET_PC)
                 | (pc_q >= PC_LIMIT);

    assign instr_d = fault ? 32'd0 : im_instr;

    always_ff @(posedge clk) begin
        if (reset) begin
            if_id_exc <= 1'b0;
        end else if (!stall) begin
            if_id_exc <= fault;
        end
    end
`else
    assign instr_d   = im_instr;
    assign if_id_exc = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            if_id_instr <= 32'd0;
            if_id_pc    <= 32'd0;
            if_id_pc8   <= 32'd8;
            if_id_valid <= 1'b0;
        end else if (!stall) begin
            pc_q        <= npc;
            if_id_instr <= instr_d;
            if_id_pc    <= pc_q;
            if_id_pc8   <= pc_q + 32'd8;
            if_id_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed vector table for ifu_fetch followed by
// random stimulus checked against a behavioural fetch model.
module tb_ifu_fetch;

`ifdef IFU_ADEL_EN
    localparam bit ADEL = 1'b1;
`else
    localparam bit ADEL = 1'b0;
`endif
    localparam logic [31:0] RPC = 32'h0000_3000;
    localparam int unsigned NW  = 1024;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [1:0]  npc_op;
    logic [31:0] id_pc;
    logic [15:0] id_imm16;
    logic [25:0] id_index26;
    logic [31:0] id_rs_val;
    logic [31:0] im_addr;
    logic [31:0] im_instr;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc8;
    logic        if_id_valid;
    logic        if_id_exc;

    logic [31:0] mem [NW];

    int checks = 0;
    int errors = 0;

    assign im_instr = mem[im_addr[11:2]];

    ifu_fetch #(.RESET_PC(RPC), .IM_WORDS(NW)) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .npc_op     (npc_op),
        .id_pc      (id_pc),
        .id_imm16   (id_imm16),
        .id_index26 (id_index26),
        .id_rs_val  (id_rs_val),
        .im_addr    (im_addr),
        .im_instr   (im_instr),
        .if_id_instr(if_id_instr),
        .if_id_pc   (if_id_pc),
        .if_id_pc8  (if_id_pc8),
        .if_id_valid(if_id_valid),
        .if_id_exc  (if_id_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          stl;
        logic [1:0]  op;
        logic [31:0] ipc;
        logic [15:0] imm;
        logic [25:0] idx;
        logic [31:0] rs;
        logic [31:0] e_addr;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        bit          e_valid;
        bit          e_flt;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] a,
                             input logic [31:0] ins, input logic [31:0] p,
                             input bit v, input bit ex);
        chk({tag, " im_addr"}, im_addr, a);
        chk({tag, " instr"}, if_id_instr, ins);
        chk({tag, " pc"}, if_id_pc, p);
        chk({tag, " pc8"}, if_id_pc8, p + 32'd8);
        chk({tag, " valid"}, {31'd0, if_id_valid}, {31'd0, v});
        chk({tag, " exc"}, {31'd0, if_id_exc}, {31'd0, ex});
    endtask

    task automatic drive(input bit r, input bit s, input logic [1:0] o,
                         input logic [31:0] ip, input logic [15:0] im,
                         input logic [25:0] ix, input logic [31:0] rv);
        reset      = r;
        stall      = s;
        npc_op     = o;
        id_pc      = ip;
        id_imm16   = im;
        id_index26 = ix;
        id_rs_val  = rv;
    endtask

    function automatic vec_t mk(bit r, bit s, logic [1:0] o,
                                logic [31:0] ip, logic [15:0] im,
                                logic [25:0] ix, logic [31:0] rv,
                                logic [31:0] ea, logic [31:0] ei,
                                logic [31:0] ep, bit ev, bit ef);
        vec_t v;
        v.rst = r; v.stl = s; v.op = o; v.ipc = ip; v.imm = im;
        v.idx = ix; v.rs = rv; v.e_addr = ea; v.e_instr = ei;
        v.e_pc = ep; v.e_valid = ev; v.e_flt = ef;
        return v;
    endfunction

    // Behavioural model state
    logic [31:0] m_pc, m_ins, m_ipc;
    bit          m_v, m_ex;

    function automatic logic [31:0] ref_npc(logic [1:0] o, logic [31:0] cur,
                                            logic [31:0] ip, logic [15:0] im,
                                            logic [25:0] ix, logic [31:0] rv);
        int s;
        case (o)
            2'd0: return cur + 32'd4;
            2'd1: begin
                s = int'(im);
                if (s > 32767) s = s - 65536;
                return ip + 32'd4 + 32'(s * 4);
            end
            2'd2: return ((ip + 32'd4) & 32'hF000_0000) + 32'(ix) * 32'd4;
            default: return rv;
        endcase
    endfunction

    function automatic bit ref_fault(logic [31:0] p);
        return (p % 4 != 0) || (p < RPC) || (p >= RPC + 4 * NW);
    endfunction

    task automatic model_step();
        bit f;
        if (reset) begin
            m_pc = RPC; m_ins = 0; m_ipc = 0; m_v = 0; m_ex = 0;
        end else if (!stall) begin
            f     = ADEL && ref_fault(m_pc);
            m_ins = f ? 32'd0 : mem[(m_pc / 4) % NW];
            m_ex  = f;
            m_ipc = m_pc;
            m_v   = 1;
            m_pc  = ref_npc(npc_op, m_pc, id_pc, id_imm16,
                            id_index26, id_rs_val);
        end
    endtask

    initial begin
        logic [31:0] w;
        for (int i = 0; i < int'(NW); i++)
            mem[i] = 32'h1000_0000 | i;
        drive(1, 0, 0, 0, 0, 0, 0);

        // rst stl op  id_pc   imm     idx      rs         addr       instr      pc        v  flt
        vt.push_back(mk(1,0,0,0,0,0,0,             32'h3000,0,0,0,0));
        vt.push_back(mk(1,0,0,0,0,0,0,             32'h3000,0,0,0,0));
        vt.push_back(mk(0,0,0,0,0,0,0,             32'h3004,32'h1000_0000,32'h3000,1,0));
        vt.push_back(mk(0,0,0,0,0,0,0,             32'h3008,32'h1000_0001,32'h3004,1,0));
        vt.push_back(mk(0,0,1,32'h3004,16'hFFFF,0,0,32'h3004,32'h1000_0002,32'h3008,1,0));
        vt.push_back(mk(0,0,1,32'h3004,16'h0003,0,0,32'h3014,32'h1000_0001,32'h3004,1,0));
        vt.push_back(mk(0,0,2,32'h3010,0,26'hC40,0, 32'h3100,32'h1000_0005,32'h3014,1,0));
        vt.push_back(mk(0,0,3,0,0,0,32'h3020,      32'h3020,32'h1000_0040,32'h3100,1,0));
        for (int k = 0; k < 3; k++)
            vt.push_back(mk(0,1,1,32'h3004,16'h0003,0,0,32'h3020,32'h1000_0040,32'h3100,1,0));
        vt.push_back(mk(0,0,0,0,0,0,0,             32'h3024,32'h1000_0008,32'h3020,1,0));
        vt.push_back(mk(0,0,0,0,0,0,0,             32'h3028,32'h1000_0009,32'h3024,1,0));
        vt.push_back(mk(1,1,1,32'h3004,16'h0003,0,0,32'h3000,0,0,0,0));
        vt.push_back(mk(1,0,2,32'h3010,0,26'hC40,0, 32'h3000,0,0,0,0));
        vt.push_back(mk(0,1,0,0,0,0,0,             32'h3000,0,0,0,0));
        vt.push_back(mk(0,0,0,0,0,0,0,             32'h3004,32'h1000_0000,32'h3000,1,0));
        vt.push_back(mk(0,0,3,0,0,0,32'hFFFF_FFFC, 32'hFFFF_FFFC,32'h1000_0001,32'h3004,1,0));
        vt.push_back(mk(0,0,0,0,0,0,0,             32'h0000_0000,32'h1000_03FF,32'hFFFF_FFFC,1,1));
        vt.push_back(mk(0,0,3,0,0,0,32'h3002,      32'h3002,32'h1000_0000,32'h0,1,1));
        vt.push_back(mk(0,0,0,0,0,0,0,             32'h3006,32'h1000_0000,32'h3002,1,1));
        vt.push_back(mk(0,0,1,32'h3000,16'h7FFF,0,0,32'h0002_3000,32'h1000_0001,32'h3006,1,1));

        #2;
        chk("pre-edge im_addr", im_addr, im_addr);
        checks--;
        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].rst, vt[i].stl, vt[i].op, vt[i].ipc,
                  vt[i].imm, vt[i].idx, vt[i].rs);
            @(posedge clk);
            #2;
            w = (ADEL && vt[i].e_flt) ? 32'd0 : vt[i].e_instr;
            check_all($sformatf("vec%0d", i), vt[i].e_addr, w,
                      vt[i].e_pc, vt[i].e_valid, ADEL && vt[i].e_flt);
        end

        // Random phase against the behavioural model
        for (int i = 0; i < int'(NW); i++)
            mem[i] = $urandom;
        drive(1, 0, 0, 0, 0, 0, 0);
        model_step();
        @(posedge clk);
        #2;
        check_all("rnd reset", m_pc, m_ins, m_ipc, m_v, m_ex);
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 49) == 0,
                  $urandom_range(0, 3) == 0,
                  2'($urandom_range(0, 3)),
                  RPC + 32'($urandom_range(0, NW - 1) * 4),
                  16'($urandom),
                  26'($urandom),
                  ($urandom_range(0, 3) == 0) ? $urandom
                      : RPC + 32'($urandom_range(0, 4 * NW - 1)));
            model_step();
            @(posedge clk);
            #2;
            check_all($sformatf("rnd%0d", n), m_pc, m_ins, m_ipc,
                      m_v, m_ex);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit: the requester side of the instruction memory.
- Owns the PC register and drives the word address to the combinational instruction memory (read index = PC[11:2]).
- Captures the returned instruction into the IF/ID pipeline register.
- Computes the next PC from the decode-stage redirect request, using MIPS delay-slot semantics: a branch or jump resolves in ID, so the delay-slot instruction is already fetched and is never squashed.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- IM_WORDS, 1024, instruction memory depth in words. Used only by the optional fault check.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hazard stall from decode; freezes PC and IF/ID.
- npc_op  input  2  next-PC select from ID: 0 = sequential, 1 = taken branch, 2 = j/jal, 3 = jr/jalr.
- id_pc  input  32  PC of the instruction currently in ID.
- id_imm16  input  16  branch offset field of the ID instruction.
- id_index26  input  26  jump index field of the ID instruction.
- id_rs_val  input  32  forwarded rs value for jr/jalr.
- im_addr  output  32  byte address to instruction memory (= pc_q).
- im_instr  input  32  instruction word returned combinationally by memory.
- if_id_instr  output  32  registered instruction for ID.
- if_id_pc  output  32  registered PC of if_id_instr.
- if_id_pc8  output  32  if_id_pc + 8, the link value for jal/jalr.
- if_id_valid  output  1  IF/ID holds a real fetched instruction.
- if_id_exc  output  1  fetch fault flag. Constant 0 unless IFU_ADEL_EN is defined.

Behaviour:
- Clock and reset: one clock (clk). reset is synchronous and active-high, and it overrides stall and npc_op.
- Reset values:
  - pc_q = RESET_PC
  - if_id_instr = 0 (nop)
  - if_id_pc = 0
  - if_id_pc8 = 8
  - if_id_valid = 0
  - if_id_exc = 0
- im_addr = pc_q, combinational. There is no memory handshake; im_instr is valid in the same cycle.
- Normal cycle (reset=0, stall=0):
  - pc_q <= npc
  - if_id_instr <= im_instr
  - if_id_pc <= pc_q
  - if_id_pc8 <= pc_q + 8
  - if_id_valid <= 1
- npc selection:
  - npc_op 0: pc_q + 4.
  - npc_op 1: id_pc + 4 + (sign_extend(id_imm16) << 2).
  - npc_op 2: {(id_pc + 4)[31:28], id_index26, 2'b00}.
  - npc_op 3: id_rs_val, used unmodified.
- Latency: an instruction is presented on im_addr in cycle N and appears on if_id_instr after edge N+1. A redirect asserted in cycle N takes effect on im_addr after edge N+1.
- Delay slot: when ID redirects, the fetch in the same cycle is the delay slot. It is latched into IF/ID normally and is never flushed.
- Stall (stall=1, reset=0):
  - pc_q and all if_id_* registers hold their values.
  - npc_op is ignored. ID is also frozen, so it re-presents the redirect on the first unstalled cycle.
- Arithmetic: all additions are 32-bit modulo 2^32. pc_q + 4 from 32'hFFFF_FFFC wraps to 0. Carries are discarded.
- Alignment: without the optional feature, misaligned targets pass through unchanged. Only PC[11:2] reaches the memory.
- Reset mid-stall or mid-redirect: reset wins and the pending redirect is lost.
- If reset and stall are both high for several cycles, outputs stay at their reset values. Fetch resumes at RESET_PC on the first cycle with reset=0 and stall=0.

Optional Feature:
- Macro: IFU_ADEL_EN.
- Defined:
  - In each cycle a fetch fault is computed as pc_q[1:0] != 0, or pc_q < RESET_PC, or pc_q >= RESET_PC + 4*IM_WORDS.
  - On an unstalled edge with a fault, if_id_instr <= 0 (nop) and if_id_exc <= 1. if_id_pc still records the faulting pc_q.
  - PC sequencing is otherwise unchanged.
- Undefined: if_id_exc is tied to 0 and the fault logic is absent.

Test Plan:
- Reset: hold reset 2 cycles, then release. Expect im_addr=0x3000, if_id_valid=0, if_id_instr=0 during reset. After the first edge: if_id_pc=0x3000, if_id_pc8=0x3008, valid=1, im_addr=0x3004.
- Sequential: memory words 0x3000..0x300C = A, B, C, D, npc_op=0. Expect if_id_instr sequence A, B, C, D on consecutive edges with if_id_pc 0x3000, 0x3004, 0x3008, 0x300C.
- Branch with delay slot: at im_addr=0x3008, drive npc_op=1, id_pc=0x3004, id_imm16=0xFFFF. Expect 0x3008 latched as delay slot, then next im_addr=0x3004. Then id_imm16=0x0003 gives 0x3014.
- Jump/jr: npc_op=2, id_pc=0x3010, id_index26=0x0000C40 gives im_addr=0x3100. npc_op=3, id_rs_val=0x3020 gives im_addr=0x3020.
- Stall: assert stall for 3 cycles with npc_op=1. Expect im_addr, if_id_instr and if_id_pc unchanged for all 3 edges. After release with npc_op=0, sequential fetch resumes from the held PC.
- IFU_ADEL_EN: npc_op=3, id_rs_val=0x3002. Expect the next edge to give if_id_instr=0, if_id_exc=1, if_id_pc=0x3002. With the macro undefined, if_id_exc stays 0.
